// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the priority interrupt controller: FSM state
// encodings and the default handler base address.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_VEC = 32'h0000_0180;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Combinational lowest-index-first priority encoder: id is the index of the
// lowest set bit of req, valid flags that any bit is set.
module intr_ctrl_prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (that would infer a latch).
    id    = '0;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: rising-edge detection on the device lines,
// pending/mask registers, and an irq/ack/eoi handshake FSM that presents one
// unmasked request at a time together with its handler vector.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int          N_SRC    = 4,
  parameter int          ID_W     = 2,
  parameter logic [31:0] BASE_VEC = DEFAULT_BASE_VEC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wd,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [31:0]      irq_vec,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);

  state_e             state_q;
  logic [N_SRC-1:0]   prev_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic               irq_q;
  logic               busy_q;
  logic [ID_W-1:0]    irq_id_q;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   clr;
  logic               accept;
  logic [ID_W-1:0]    enc_id;
  logic               enc_valid;

  // Only an ack while a request is outstanding consumes the pending bit.
  assign accept = (state_q == ST_REQ) && ack;
  assign rise   = src_in & ~prev_q;
  assign mask_d = mask_we ? mask_wd : mask_q;

  // Pending next state: a coincident rise re-arms the bit being cleared.
  always_comb begin
    clr = '0;
    if (accept) begin
      clr[irq_id_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | rise;
  end

  intr_ctrl_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (pending_q & ~mask_q),
    .id    (enc_id),
    .valid (enc_valid)
  );

  // Edge-detect history, pending and mask registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      prev_q    <= src_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Handshake FSM with registered irq/busy/irq_id outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      busy_q   <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enc_valid) begin
            irq_id_q <= enc_id;
            irq_q    <= 1'b1;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // ack takes precedence over a same-edge mask write on this source.
          if (ack) begin
            irq_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SERVICE;
          end else if (mask_d[irq_id_q]) begin
            irq_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq     = irq_q;
  assign busy    = busy_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign irq_vec = BASE_VEC + 32'({irq_id_q, 3'b000});

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed, table-driven bench for intr_ctrl plus hand-written reset sequences.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_in;
  logic        mask_we;
  logic [3:0]  mask_wd;
  logic        ack;
  logic        eoi;
  logic        irq;
  logic [1:0]  irq_id;
  logic [31:0] irq_vec;
  logic        busy;
  logic [3:0]  pending;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] src;
    logic       mwe;
    logic [3:0] mwd;
    logic       ack;
    logic       eoi;
    logic       e_irq;
    logic [1:0] e_id;
    logic       e_busy;
    logic [3:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  intr_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .src_in  (src_in),
    .mask_we (mask_we),
    .mask_wd (mask_wd),
    .ack     (ack),
    .eoi     (eoi),
    .irq     (irq),
    .irq_id  (irq_id),
    .irq_vec (irq_vec),
    .busy    (busy),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] src, input logic mwe, input logic [3:0] mwd,
                     input logic a, input logic e, input logic e_irq,
                     input logic [1:0] e_id, input logic e_busy, input logic [3:0] e_pend);
    vec_t v;
    v.src = src; v.mwe = mwe; v.mwd = mwd; v.ack = a; v.eoi = e;
    v.e_irq = e_irq; v.e_id = e_id; v.e_busy = e_busy; v.e_pend = e_pend;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    src_in = 4'b0000; mask_we = 1'b0; mask_wd = 4'b0000; ack = 1'b0; eoi = 1'b0;
  endtask

  initial begin
    // Columns: src mwe mwd ack eoi | irq id busy pending (after the edge)
    // Single source 2
    add(4'b0100, 0, 4'b0000, 0, 0,  0, 2'd0, 0, 4'b0100);
    add(4'b0000, 0, 4'b0000, 0, 0,  1, 2'd2, 0, 4'b0100);
    add(4'b0000, 0, 4'b0000, 1, 0,  0, 2'd2, 1, 4'b0000);
    add(4'b0000, 0, 4'b0000, 0, 0,  0, 2'd2, 1, 4'b0000);
    add(4'b0000, 0, 4'b0000, 0, 1,  0, 2'd2, 0, 4'b0000);
    add(4'b0000, 0, 4'b0000, 1, 0,  0, 2'd2, 0, 4'b0000);  // ack in IDLE ignored
    // Priority 3 vs 1
    add(4'b1010, 0, 4'b0000, 0, 0,  0, 2'd2, 0, 4'b1010);
    add(4'b0000, 0, 4'b0000, 0, 0,  1, 2'd1, 0, 4'b1010);
    add(4'b0000, 0, 4'b0000, 1, 0,  0, 2'd1, 1, 4'b1000);
    add(4'b0000, 0, 4'b0000, 0, 1,  0, 2'd1, 0, 4'b1000);
    add(4'b0000, 0, 4'b0000, 0, 0,  1, 2'd3, 0, 4'b1000);
    add(4'b0000, 0, 4'b0000, 1, 0,  0, 2'd3, 1, 4'b0000);
    add(4'b0000, 0, 4'b0000, 0, 1,  0, 2'd3, 0, 4'b0000);
    // Masking source 0
    add(4'b0000, 1, 4'b0001, 0, 0,  0, 2'd3, 0, 4'b0000);
    add(4'b0001, 0, 4'b0000, 0, 0,  0, 2'd3, 0, 4'b0001);
    add(4'b0000, 0, 4'b0000, 0, 0,  0, 2'd3, 0, 4'b0001);
    add(4'b0000, 0, 4'b0000, 0, 0,  0, 2'd3, 0, 4'b0001);
    add(4'b0000, 1, 4'b0000, 0, 0,  0, 2'd3, 0, 4'b0001);
    add(4'b0000, 0, 4'b0000, 0, 0,  1, 2'd0, 0, 4'b0001);
    add(4'b0000, 1, 4'b0001, 0, 0,  0, 2'd0, 0, 4'b0001);  // withdraw in REQ
    add(4'b0000, 0, 4'b0000, 0, 0,  0, 2'd0, 0, 4'b0001);
    add(4'b0000, 1, 4'b0000, 0, 0,  0, 2'd0, 0, 4'b0001);
    add(4'b0000, 0, 4'b0000, 0, 0,  1, 2'd0, 0, 4'b0001);
    add(4'b0000, 1, 4'b0001, 1, 0,  0, 2'd0, 1, 4'b0000);  // ack beats mask write
    add(4'b0000, 0, 4'b0000, 0, 1,  0, 2'd0, 0, 4'b0000);
    add(4'b0000, 0, 4'b0000, 0, 1,  0, 2'd0, 0, 4'b0000);  // eoi in IDLE ignored
    add(4'b0000, 1, 4'b0000, 0, 0,  0, 2'd0, 0, 4'b0000);
    // Collision: re-raise source 2 on the ack edge
    add(4'b0100, 0, 4'b0000, 0, 0,  0, 2'd0, 0, 4'b0100);
    add(4'b0000, 0, 4'b0000, 0, 0,  1, 2'd2, 0, 4'b0100);
    add(4'b0100, 0, 4'b0000, 1, 0,  0, 2'd2, 1, 4'b0100);
    add(4'b0000, 0, 4'b0000, 0, 0,  0, 2'd2, 1, 4'b0100);
    add(4'b0000, 0, 4'b0000, 0, 1,  0, 2'd2, 0, 4'b0100);
    add(4'b0000, 0, 4'b0000, 0, 0,  1, 2'd2, 0, 4'b0100);
    add(4'b0000, 0, 4'b0000, 1, 0,  0, 2'd2, 1, 4'b0000);  // ends in SERVICE

    // Reset with all lines high
    idle_inputs();
    src_in = 4'b1111;
    reset  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_vec", irq_vec, 32'h0000_0180);
    reset = 1'b1;
    @(negedge clk);
    check("release_pending", 32'(pending), 32'hf);
    check("release_irq", 32'(irq), 32'd0);
    @(negedge clk);
    check("release_irq_id0", {31'd0, irq} | (32'(irq_id) << 4), 32'h1);

    // Clean restart for the table
    reset  = 1'b0;
    src_in = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("restart_pending", 32'(pending), 32'd0);

    foreach (vecs[i]) begin
      src_in  = vecs[i].src;
      mask_we = vecs[i].mwe;
      mask_wd = vecs[i].mwd;
      ack     = vecs[i].ack;
      eoi     = vecs[i].eoi;
      @(negedge clk);
      check($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
      check($sformatf("v%0d_id", i), 32'(irq_id), 32'(vecs[i].e_id));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_pend", i), 32'(pending), 32'(vecs[i].e_pend));
      check($sformatf("v%0d_vec", i), irq_vec, 32'h180 + 32'(vecs[i].e_id) * 32'd8);
    end
    idle_inputs();

    // Async reset in SERVICE: outputs clear before any clock edge
    src_in = 4'b0010;
    @(negedge clk);
    check("pre_async_busy", 32'(busy), 32'd1);
    check("pre_async_pend", 32'(pending), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_irq", 32'(irq), 32'd0);
    check("async_pending", 32'(pending), 32'd0);
    check("async_id", 32'(irq_id), 32'd0);
    #2;
    src_in = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_async_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
